// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if: ID-stage inputs and per-stage control outputs of pipe_ctrl_unit
//   inputs : id_inst_i, id_valid_i, flush_i
//   outputs: id_extop_o, stall_o (combinational); ex_*, mem_*, wb_*, illegal_o,
//            stall_cnt_o (registered)
interface pipe_ctrl_unit_if #(
    parameter int ALUOP_W = 5,
    parameter int EXTOP_W = 6,
    parameter int PERF_W  = 16
);
    logic [31:0]        id_inst_i;
    logic               id_valid_i;
    logic               flush_i;
    logic [EXTOP_W-1:0] id_extop_o;
    logic               stall_o;
    logic [ALUOP_W-1:0] ex_aluop_o;
    logic               ex_alusrc_o;
    logic               ex_branch_o;
    logic [1:0]         ex_jump_o;
    logic [2:0]         ex_funct3_o;
    logic               mem_we_o;
    logic [2:0]         mem_dmtype_o;
    logic               wb_regwrite_o;
    logic [1:0]         wb_wdsel_o;
    logic [4:0]         wb_rd_o;
    logic               illegal_o;
    logic [PERF_W-1:0]  stall_cnt_o;
    modport master (
        output id_inst_i, id_valid_i, flush_i,
        input  id_extop_o, stall_o, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_jump_o,
               ex_funct3_o, mem_we_o, mem_dmtype_o, wb_regwrite_o, wb_wdsel_o, wb_rd_o,
               illegal_o, stall_cnt_o
    );
    modport slave (
        input  id_inst_i, id_valid_i, flush_i,
        output id_extop_o, stall_o, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_jump_o,
               ex_funct3_o, mem_we_o, mem_dmtype_o, wb_regwrite_o, wb_wdsel_o, wb_rd_o,
               illegal_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined RV32I control unit with load-use stall, flush and stall counter
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset, clears every stage to a NOP bubble
//   bus  : slave side of pipe_ctrl_unit_if (ID instruction in, stage controls out)
module pipe_ctrl_unit #(
    parameter int ALUOP_W = 5,
    parameter int EXTOP_W = 6,
    parameter int PERF_W  = 16
) (
    input logic             clk,
    input logic             rstn,
    pipe_ctrl_unit_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(10);
    localparam logic [EXTOP_W-1:0] EXT_I     = EXTOP_W'(0);
    localparam logic [EXTOP_W-1:0] EXT_SHAMT = EXTOP_W'(1);
    localparam logic [EXTOP_W-1:0] EXT_S     = EXTOP_W'(2);
    localparam logic [EXTOP_W-1:0] EXT_B     = EXTOP_W'(3);
    localparam logic [EXTOP_W-1:0] EXT_U     = EXTOP_W'(4);
    localparam logic [EXTOP_W-1:0] EXT_J     = EXTOP_W'(5);
    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               branch;
        logic [1:0]         jump;
        logic [2:0]         funct3;
        logic               illegal;
        logic               we;
        logic [2:0]         dmtype;
        logic               regwrite;
        logic [1:0]         wdsel;
        logic [4:0]         rd;
    } ctrl_t;
    typedef struct packed {
        logic       we;
        logic [2:0] dmtype;
        logic       regwrite;
        logic [1:0] wdsel;
        logic [4:0] rd;
    } mem_t;
    typedef struct packed {
        logic       regwrite;
        logic [1:0] wdsel;
        logic [4:0] rd;
    } wb_t;
    logic [31:0]        inst;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [4:0]         rs1, rs2;
    logic               use1, use2, hazard, stall;
    logic [EXTOP_W-1:0] ext;
    ctrl_t              dec, ex_d, ex_q;
    mem_t               mem_q;
    wb_t                wb_q;
    logic [PERF_W-1:0]  cnt_d, cnt_q;
    logic               unused_bits;
    assign inst        = bus.id_inst_i;
    assign opc         = inst[6:0];
    assign f3          = inst[14:12];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = ^{inst[31], inst[29:25]};
    function automatic logic [ALUOP_W-1:0] alu_f(input logic [2:0] f, input logic alt);
        case (f)
            3'd0:    alu_f = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_f = ALU_SLL;
            3'd2:    alu_f = ALU_SLT;
            3'd3:    alu_f = ALU_SLTU;
            3'd4:    alu_f = ALU_XOR;
            3'd5:    alu_f = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_f = ALU_OR;
            default: alu_f = ALU_AND;
        endcase
    endfunction
    // loads and stores share the funct3 size encoding
    function automatic logic [2:0] dm_f(input logic [2:0] f);
        case (f)
            3'd0:    dm_f = DM_B;
            3'd1:    dm_f = DM_H;
            3'd4:    dm_f = DM_BU;
            3'd5:    dm_f = DM_HU;
            default: dm_f = DM_W;
        endcase
    endfunction
    always_comb begin
        dec        = '0;
        dec.funct3 = f3;
        ext        = EXT_I;
        use1       = 1'b0;
        use2       = 1'b0;
        case (opc)
            OP_R: begin
                dec.aluop    = alu_f(f3, inst[30]);
                dec.regwrite = 1'b1;
                dec.rd       = inst[11:7];
                use1         = 1'b1;
                use2         = 1'b1;
            end
            OP_I: begin
                // funct7[5] only selects SRAI; for ADDI it is an immediate bit
                dec.aluop    = alu_f(f3, f3 == 3'd5 && inst[30]);
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.rd       = inst[11:7];
                ext          = (f3 == 3'd1 || f3 == 3'd5) ? EXT_SHAMT : EXT_I;
                use1         = 1'b1;
            end
            OP_LD: begin
                dec.alusrc   = 1'b1;
                dec.dmtype   = dm_f(f3);
                dec.regwrite = 1'b1;
                dec.wdsel    = 2'b01;
                dec.rd       = inst[11:7];
                use1         = 1'b1;
            end
            OP_ST: begin
                dec.alusrc = 1'b1;
                dec.we     = 1'b1;
                dec.dmtype = dm_f(f3);
                ext        = EXT_S;
                use1       = 1'b1;
                use2       = 1'b1;
            end
            OP_BR: begin
                dec.aluop  = ALU_SUB;
                dec.branch = 1'b1;
                ext        = EXT_B;
                use1       = 1'b1;
                use2       = 1'b1;
            end
            OP_JAL: begin
                dec.jump     = 2'b01;
                dec.regwrite = 1'b1;
                dec.wdsel    = 2'b10;
                dec.rd       = inst[11:7];
                ext          = EXT_J;
            end
            OP_JALR: begin
                dec.alusrc   = 1'b1;
                dec.jump     = 2'b10;
                dec.regwrite = 1'b1;
                dec.wdsel    = 2'b10;
                dec.rd       = inst[11:7];
                use1         = 1'b1;
            end
            OP_LUI: begin
                dec.aluop    = ALU_LUI;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.rd       = inst[11:7];
                ext          = EXT_U;
            end
            OP_AUIPC: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.rd       = inst[11:7];
                ext          = EXT_U;
            end
            default: begin
                dec         = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end
    // only loads write back from memory, so wdsel = 01 marks a load in ID/EX
    assign hazard = bus.id_valid_i && ex_q.wdsel == 2'b01 && ex_q.rd != 5'd0 &&
                    ((use1 && rs1 == ex_q.rd) || (use2 && rs2 == ex_q.rd));
    assign stall  = hazard && !bus.flush_i;
    assign ex_d   = (!bus.id_valid_i || bus.flush_i || stall) ? '0 : dec;
    assign cnt_d  = (stall && cnt_q != '1) ? cnt_q + PERF_W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{we: ex_q.we, dmtype: ex_q.dmtype, regwrite: ex_q.regwrite,
                       wdsel: ex_q.wdsel, rd: ex_q.rd};
            wb_q  <= '{regwrite: mem_q.regwrite, wdsel: mem_q.wdsel, rd: mem_q.rd};
            cnt_q <= cnt_d;
        end
    end
    assign bus.id_extop_o    = ext;
    assign bus.stall_o       = stall;
    assign bus.ex_aluop_o    = ex_q.aluop;
    assign bus.ex_alusrc_o   = ex_q.alusrc;
    assign bus.ex_branch_o   = ex_q.branch;
    assign bus.ex_jump_o     = ex_q.jump;
    assign bus.ex_funct3_o   = ex_q.funct3;
    assign bus.illegal_o     = ex_q.illegal;
    assign bus.mem_we_o      = mem_q.we;
    assign bus.mem_dmtype_o  = mem_q.dmtype;
    assign bus.wb_regwrite_o = wb_q.regwrite;
    assign bus.wb_wdsel_o    = wb_q.wdsel;
    assign bus.wb_rd_o       = wb_q.rd;
    assign bus.stall_cnt_o   = cnt_q;
endmodule
